uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: 8N1 frames (1 start, 8 data bits LSB first, 1 stop) on the asynchronous serial line rx are recovered into bytes.
- Pairs with the team's existing uart_tx, using the same CLK_PER_BIT bit timing.
- Oversampling is by counter: start-bit validation at mid-bit, each data and stop bit sampled at its centre.
- Sits at the chip pin, behind a 2-flop synchronizer, and feeds a byte-wide one-cycle valid strobe to the downstream consumer.

Parameters:
- CLK_PER_BIT, 434, clk cycles per bit (e.g. 50 MHz / 115200). Legal range 4..65535.
- HALF_BIT, CLK_PER_BIT/2 (derived localparam), mid-bit offset used for start-bit validation.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous to clk, idle high
- data_out  output  8  last correctly received byte
- rx_valid  output  1  one-cycle pulse: data_out updated with a good frame
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high while a frame is in progress

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, data_out=8'h00, rx_valid=0, frame_err=0, busy=0, counters=0. Synchronizer flops reset to 1 (line idle).
- Input path: rx goes through a 2-flop synchronizer to rx_s, then a third flop to rx_d. Falling edge is rx_d=1 && rx_s=0. Edge detection, not a level check, prevents a held-low line (break) from retriggering.
- clk_cnt is 16 bits; bit_idx is 3 bits; shift register is 8 bits.
- IDLE: busy=0, clk_cnt=0. On falling edge, go to START and set busy=1.
- START: count to HALF_BIT-1.
  - rx_s=0 at that point: valid start. Go to DATA with clk_cnt=0, bit_idx=0.
  - rx_s=1 at that point: glitch. Return to IDLE with no output pulse.
- DATA: count to CLK_PER_BIT-1, then sample rx_s into shift[bit_idx] (LSB first) and clear clk_cnt.
  - bit_idx=7: go to STOP.
  - Otherwise: increment bit_idx.
- STOP: count to CLK_PER_BIT-1, then sample rx_s.
  - 1: data_out<=shift and rx_valid=1 for exactly one cycle.
  - 0: frame_err=1 for one cycle and data_out is unchanged.
  - Either case: go to IDLE the same cycle. busy drops the cycle after the sample.
- Rx is not held for the remaining half stop bit. This allows back-to-back frames whose start edge arrives one half bit later.
- rx_valid and frame_err are mutually exclusive and never asserted for two consecutive cycles.
- Latency: rx_valid asserts HALF_BIT + 9*CLK_PER_BIT cycles after the falling-edge detect, plus 3 cycles of input pipeline from the rx pin. The bench tolerates ±2 cycles.
- No overrun protection: the consumer must take data_out on rx_valid. data_out is stable until the next good frame.
- Reset mid-frame: everything returns to reset values immediately. The next frame is accepted only after rx has been seen high and then falls.
- Line held low indefinitely: one frame_err, then IDLE with no further activity until rx rises and falls again.

Decomposition:
- uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP), shared with uart_tx;
  - the default CLK_PER_BIT constant;
  - the frame constants DATA_BITS=8 and STOP_LEVEL=1'b1.
- One sub-module, uart_sync: 2-flop synchronizer with a reset-value parameter, reusable for other async inputs.

Test Plan (CLK_PER_BIT=16 for speed; one full-rate run at 434):
- uart_tx loopback sends 8'hA5 -> data_out=8'hA5 with one rx_valid pulse, frame_err=0, busy=0 after the frame.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three rx_valid pulses, data_out 00, FF, 55 in order, no frame_err.
- rx pulsed low for 5 cycles (less than HALF_BIT) -> no rx_valid, no frame_err, busy high for 8 cycles then 0.
- Frame 8'h3C with stop bit driven 0, following a good 8'h11 -> frame_err pulse of one cycle, rx_valid=0, data_out stays 8'h11.
- rst_n pulsed low during bit 4 of a frame -> outputs go to reset values immediately. The remainder of that frame produces no pulse. The next clean frame 8'h7E is received correctly.
- Line held low for 20 bit times -> exactly one frame_err. After rx returns high, frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and 8N1 frame constants.
package uart_pkg;
  localparam int       CLK_PER_BIT_DEF = 434;
  localparam int       DATA_BITS       = 8;
  localparam logic     STOP_LEVEL      = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; reset value chosen per use (idle level).
module uart_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: counter-based mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int          HALF_BIT  = CLK_PER_BIT / 2;
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

  uart_state_e state, state_n;
  logic [15:0] clk_cnt, cnt_n;
  logic [2:0]  bit_idx, idx_n;
  logic [7:0]  shift, shift_n, dout_n;
  logic        vld_n, err_n;
  logic        rx_s, rx_d, armed, fall;
  logic [1:0]  warm;

  uart_sync #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // The sync flops come out of reset holding "idle", so a line that is low at
  // reset release would look like a falling edge. Only arm edge detection once
  // a real high sample has passed through the synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d  <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_d  <= rx_s;
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & rx_s);
    end
  end

  assign fall = armed & rx_d & ~rx_s;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt;
    idx_n   = bit_idx;
    shift_n = shift;
    dout_n  = data_out;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_n          = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) state_n = STOP;
          else                     idx_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s == STOP_LEVEL) begin
            dout_n = shift;
            vld_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_cnt   <= cnt_n;
      bit_idx   <= idx_n;
      shift     <= shift_n;
      data_out  <= dout_n;
      rx_valid  <= vld_n;
      frame_err <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: bit-banged frames in, expected bytes/errors queued and checked on each strobe.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid, frame_err, busy;

  exp_t       sb[$];
  int         n_run = 0, n_fail = 0;
  int         cyc = 0, start_cyc = 0, vld_cyc = 0;
  int         n_vld = 0, n_err = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err)) begin
      exp_t e;
      chk("exclusive", {31'd0, rx_valid & frame_err}, 0);
      chk("pulse_gap", {31'd0, prev_pulse}, 0);
      if (rx_valid) begin
        n_vld++;
        vld_cyc = cyc;
      end
      if (frame_err) n_err++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, rx_valid, 8'd0} | {23'd0, frame_err, data_out}, 0);
      end else begin
        e = sb.pop_front();
        chk("kind_err", {31'd0, frame_err}, {31'd0, e.err});
        chk("data_out", {24'd0, data_out}, {24'd0, e.data});
      end
    end
    prev_pulse = rx_valid | frame_err;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    exp_t e;
    if (stop) last_good = b;
    e.err  = ~stop;
    e.data = last_good;
    sb.push_back(e);
    start_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
    rx = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int diff, bcnt;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_vld", {31'd0, rx_valid}, 0);
    chk("rst_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    hold(1'b1, 2 * CPB);

    // single frame + latency
    send_byte(8'hA5, 1'b1);
    drain(4 * CPB);
    diff = vld_cyc - start_cyc;
    chk("latency", (diff >= LAT - 2 && diff <= LAT + 2) ? LAT : diff, LAT);
    hold(1'b1, CPB);
    chk("busy_after", {31'd0, busy}, 0);
    chk("err_after_a5", n_err, 0);

    // back-to-back, no idle gap
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    drain(4 * CPB);
    hold(1'b1, CPB);

    // short glitch: start rejected at mid-bit
    bcnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 4) rx = 1'b1;
      if (busy) bcnt++;
    end
    chk("glitch_busy", bcnt, 8);
    chk("glitch_vld", n_vld, 4);

    // bad stop bit after a good frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h3C, 1'b0);
    drain(4 * CPB);
    hold(1'b1, 2 * CPB);
    chk("err_hold_data", {24'd0, data_out}, 8'h11);
    chk("err_count", n_err, 1);

    // reset during bit 4 of 8'hF0 (bits 4..7 high so nothing false-starts after)
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b0, CPB);
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_data", {24'd0, data_out}, 0);
    chk("mid_rst_vld", {31'd0, rx_valid | frame_err}, 0);
    rst_n = 1'b1;
    last_good = 8'h00;
    hold(1'b1, 5 * CPB);
    chk("mid_rst_nopulse", n_vld, 5);
    send_byte(8'h7E, 1'b1);
    drain(4 * CPB);

    // break: line low for 20 bit times gives exactly one framing error
    begin
      exp_t e;
      e.err  = 1'b1;
      e.data = last_good;
      sb.push_back(e);
    end
    hold(1'b0, 20 * CPB);
    hold(1'b1, 2 * CPB);
    drain(4 * CPB);
    chk("break_err", n_err, 2);
    send_byte(8'hC3, 1'b1);
    drain(4 * CPB);
    hold(1'b1, 2 * CPB);

    chk("total_vld", n_vld, 7);
    chk("total_err", n_err, 2);
    chk("final_busy", {31'd0, busy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
